// File: rtl/memory_read_module.sv
// Register-file memory with a free-running, pausable read scan.
// One word is presented on oData/oAddr every T_STEP+2 cycles while unpaused.
module memory_read_module #(
  parameter logic [25:0] T_STEP = 26'd49_999_999
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       iEn,
  input  logic [3:0] iAddr,
  input  logic [3:0] iData,
  input  logic       iPause,
  output logic [3:0] oData,
  output logic [3:0] oAddr,
  output logic       oValid
);

  typedef enum logic {
    WAIT = 1'b0,
    READ = 1'b1
  } scanState_t;

  scanState_t  state;
  scanState_t  stateNext;
  logic [25:0] count;
  logic [25:0] countNext;
  logic [3:0]  rPtr;
  logic [3:0]  mem [16];

  // Writes are never stalled; the read below samples the pre-write word.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= 4'h0;
      end
    end else if (iEn) begin
      mem[iAddr] <= iData;
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state <= WAIT;
      count <= '0;
    end else begin
      state <= stateNext;
      count <= countNext;
    end
  end

  always_comb begin
    stateNext = state;
    countNext = count;
    case (state)
      WAIT: begin
        if (!iPause) begin
          if (count == T_STEP) begin
            stateNext = READ;
            countNext = '0;
          end else begin
            countNext = count + 26'd1;
          end
        end
      end
      READ:    stateNext = WAIT;
      default: stateNext = WAIT;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      oData  <= 4'h0;
      oAddr  <= 4'h0;
      oValid <= 1'b0;
      rPtr   <= 4'h0;
    end else begin
      oValid <= (state == READ);
      if (state == READ) begin
        oData <= mem[rPtr];
        oAddr <= rPtr;
        rPtr  <= rPtr + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_memory_read_module.sv
// Directed plus randomized bench for memory_read_module, checked against a
// time-to-next-read reference model with its own copy of the memory.
module tb_memory_read_module;

  localparam int TS     = 3;
  localparam int PERIOD = TS + 2;

  logic       sysclk = 1'b0;
  logic       rst;
  logic       iEn;
  logic [3:0] iAddr;
  logic [3:0] iData;
  logic       iPause;
  logic [3:0] oData;
  logic [3:0] oAddr;
  logic       oValid;

  memory_read_module #(.T_STEP(26'(TS))) dut (
    .sysclk(sysclk),
    .rst(rst),
    .iEn(iEn),
    .iAddr(iAddr),
    .iData(iData),
    .iPause(iPause),
    .oData(oData),
    .oAddr(oAddr),
    .oValid(oValid)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  // Reference model: memory image, next address to read, cycles until read.
  logic [3:0] mMem [16];
  logic [3:0] mPtr;
  int         rem;
  logic [3:0] expData;
  logic [3:0] expAddr;
  logic       expValid;

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mMem[i] = 4'h0;
    mPtr     = 4'h0;
    rem      = PERIOD;
    expData  = 4'h0;
    expAddr  = 4'h0;
    expValid = 1'b0;
  endtask

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic checkOut(input string tag);
    check({tag, "_valid"}, {3'b0, oValid}, {3'b0, expValid});
    check({tag, "_data"}, oData, expData);
    check({tag, "_addr"}, oAddr, expAddr);
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic step(input logic en, input logic [3:0] a, input logic [3:0] d, input logic p);
    iEn = en; iAddr = a; iData = d; iPause = p;
    @(posedge sysclk);
    expValid = 1'b0;
    if (rem == 1) begin
      expValid = 1'b1;
      expData  = mMem[mPtr];
      expAddr  = mPtr;
      mPtr     = mPtr + 4'd1;
      rem      = PERIOD;
    end else if (!p) begin
      rem--;
    end
    if (en) mMem[a] = d;
    #1;
    checkOut("step");
    @(negedge sysclk);
  endtask

  task automatic resetPulse();
    rst = 1'b1;
    iEn = 1'b1; iAddr = 4'h5; iData = 4'hF; iPause = 1'b0;
    modelReset();
    #1;
    checkOut("rstAsync");
    @(posedge sysclk);
    #1;
    checkOut("rstHold");
    @(negedge sysclk);
    rst = 1'b0;
    iEn = 1'b0;
  endtask

  task automatic runUntilValid(input int limit, output int n);
    n = 0;
    do begin
      step(1'b0, 4'h0, 4'h0, 1'b0);
      n++;
    end while (!oValid && n < limit);
  endtask

  int n;
  int pulses;
  int guard;

  initial begin
    rst = 1'b1; iEn = 1'b0; iAddr = 4'h0; iData = 4'h0; iPause = 1'b0;
    resetPulse();

    // All-zero scan after reset: 16 pulses, addresses 0..15.
    pulses = 0;
    for (int c = 0; c < 16 * PERIOD; c++) begin
      step(1'b0, 4'h0, 4'h0, 1'b0);
      if (oValid) pulses++;
    end
    check("zeroScanPulses", 4'(pulses), 4'd0);

    // Fill a+1 pattern and watch a full wrap.
    resetPulse();
    for (int a = 0; a < 16; a++) begin
      step(1'b1, 4'(a), (a == 15) ? 4'hF : 4'(a + 1), 1'b0);
    end
    for (int c = 0; c < 17 * PERIOD; c++) step(1'b0, 4'h0, 4'h0, 1'b0);

    // Pause for 10 cycles in WAIT delays the next pulse by exactly 10.
    runUntilValid(40, n);
    step(1'b0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b0);
    for (int c = 0; c < 10; c++) step(1'b0, 4'h0, 4'h0, 1'b1);
    runUntilValid(40, n);
    check("pauseGap", 4'(n + 12 - 10), 4'(PERIOD));

    // Write collides with the read of address 2.
    step(1'b1, 4'h2, 4'h3, 1'b0);
    guard = 0;
    while (!(rem == 1 && mPtr == 4'h2) && guard < 200) begin
      step(1'b0, 4'h0, 4'h0, 1'b0);
      guard++;
    end
    check("collideReach", 4'(guard < 200), 4'd1);
    step(1'b1, 4'h2, 4'hA, 1'b0);
    check("collideOld", oData, 4'h3);
    check("collideAddr", oAddr, 4'h2);
    guard = 0;
    do begin
      step(1'b0, 4'h0, 4'h0, 1'b0);
      guard++;
    end while (!(oValid && oAddr == 4'h2) && guard < 200);
    check("collideNew", oData, 4'hA);

    // Back-to-back writes 4,5,6 <- 7,8,9.
    step(1'b1, 4'h4, 4'h7, 1'b0);
    step(1'b1, 4'h5, 4'h8, 1'b0);
    step(1'b1, 4'h6, 4'h9, 1'b0);
    for (int c = 0; c < 17 * PERIOD; c++) step(1'b0, 4'h0, 4'h0, 1'b0);

    // Abandon the scan mid-way with rPtr=7.
    guard = 0;
    while (!(mPtr == 4'h7 && rem == 3) && guard < 200) begin
      step(1'b0, 4'h0, 4'h0, 1'b0);
      guard++;
    end
    check("midReach", 4'(guard < 200), 4'd1);
    #2;
    resetPulse();
    runUntilValid(20, n);
    check("postRstLatency", 4'(n), 4'(PERIOD));
    check("postRstAddr", oAddr, 4'h0);
    for (int c = 0; c < 15 * PERIOD; c++) step(1'b0, 4'h0, 4'h0, 1'b0);

    // Random traffic with occasional pauses.
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_read_module.md
MEMORY_READ_MODULE -- requirements
Module: memory_read_module

Interface
REQ-001 Parameter T_STEP, default 26'd49_999_999: WAIT-state dwell per entry, in cycles minus one.
REQ-002 sysclk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 iEn  input  1  write enable; one-cycle pulse per write.
REQ-005 iAddr  input  4  write address, 0..15.
REQ-006 iData  input  4  write data.
REQ-007 iPause  input  1  when high, freezes the read scan.
REQ-008 oData  output  4  most recently read memory word, held between reads.
REQ-009 oAddr  output  4  address oData was read from.
REQ-010 oValid  output  1  one-cycle pulse when oData/oAddr update.

Function
REQ-011 Storage SHALL be 16 words x 4 bits, fully register-based, cleared to 4'h0 by reset.
REQ-012 Write SHALL occur at the rising edge where iEn=1: mem[iAddr] <= iData; iEn=0 leaves storage unchanged.
REQ-013 Writes SHALL have no handshake or back-pressure; every iEn pulse is accepted in its cycle, independent of scan state and iPause.
REQ-014 Scan FSM SHALL have two states: WAIT and READ.
REQ-015 Reset state SHALL be WAIT, with count=0 and read pointer rPtr=0.
REQ-016 In WAIT with iPause=0: if count==T_STEP, next state is READ and count <= 0; otherwise count <= count+1.
REQ-017 In WAIT with iPause=1: count and state SHALL hold.
REQ-018 In READ, at the next edge: oData <= mem[rPtr], oAddr <= rPtr, oValid <= 1, rPtr <= rPtr+1, state <= WAIT.
REQ-019 READ SHALL last exactly one cycle regardless of iPause.
REQ-020 oValid SHALL be 1 only in the single cycle following the READ edge, and 0 otherwise.
REQ-021 Scan period SHALL be T_STEP+2 cycles per entry while iPause=0.
REQ-022 rPtr SHALL be 4 bits and wrap from 15 to 0 with no gap or extra cycle.
REQ-023 Simultaneous write and read of the same address in the READ cycle: oData SHALL return the pre-write value; the new value is visible on the next read of that address.
REQ-024 Write to an address other than rPtr in the READ cycle SHALL not affect oData.
REQ-025 oData/oAddr SHALL hold their last values between oValid pulses.
REQ-026 count SHALL be 26 bits; T_STEP=0 is legal and gives period 2.

Reset
REQ-027 While rst=1, asynchronously: oData=4'h0, oAddr=4'h0, oValid=0, state=WAIT, count=0, rPtr=0, all memory words=4'h0.
REQ-028 iEn asserted while rst=1 SHALL be ignored.
REQ-029 Reset asserted mid-scan SHALL abandon the scan; after release, the scan restarts at address 0 with a full WAIT dwell.
REQ-030 First oValid after reset release (iPause=0) SHALL occur T_STEP+2 cycles after the first active edge.

Verification (T_STEP=3, so period=5 cycles)
REQ-031 Write mem[a]=a+1 for a=0..14 and mem[15]=4'hF, iPause=0 -> oValid every 5 cycles; (oAddr,oData) = (0,1),(1,2)...(14,F),(15,F),(0,1), showing wrap.
REQ-032 No writes after reset -> 16 oValid pulses, each oData=0, oAddr 0..15.
REQ-033 iPause=1 held 10 cycles during WAIT -> the next oValid is delayed exactly 10 cycles, with no skipped or repeated address.
REQ-034 mem[2]=4'h3, then iEn with iAddr=2, iData=4'hA in the READ cycle for address 2 -> oData=3 for that pulse; the next scan of address 2 gives oData=A.
REQ-035 rst pulsed while rPtr=7 -> outputs 0 immediately; all memory reads 0; first post-reset oValid has oAddr=0, 5 cycles after release.
REQ-036 iEn pulses on consecutive cycles to addresses 4,5,6 with data 7,8,9 -> all three are stored, as observed on their scan reads.
